// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared state encoding and sizing helpers for the systolic
//             array sequencer and its operand skew lines.
//  Revision : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Cycles needed for the last wavefront to cross an n x n array
  function automatic int drain_cycles(input int n);
    return 2 * n;
  endfunction

  // Bits needed to number the rows of an n x n array
  function automatic int row_w(input int n);
    return $clog2(n);
  endfunction

  // Low bit of lane i in an n-lane vector of w-bit lanes (lane 0 in the MSBs)
  function automatic int lane_lo(input int n, input int w, input int i);
    return (n - 1 - i) * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_controller_skew.sv
`default_nettype none
// ============================================================================
//  Module   : skew_buffer
//  Purpose  : Delays lane i of an operand vector by i cycles so the vector
//             enters the systolic array as a diagonal wavefront. Lanes whose
//             delayed valid is low drive zero.
//  Revision : 1.0 - initial release
// ============================================================================
module skew_buffer
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] vec_i,
  input  logic                             valid_i,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] vec_o
);

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    localparam int LO = lane_lo(ARRAY_SIZE, DATA_WIDTH, i);

    if (i == 0) begin : g_pass
      assign vec_o[LO +: DATA_WIDTH] = valid_i ? vec_i[LO +: DATA_WIDTH] : '0;
    end else begin : g_delay
      logic [i-1:0][DATA_WIDTH-1:0] data_q;
      logic [i-1:0]                 valid_q;

      // Shift lane data together with its valid so bubbles stay aligned
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= '0;
        end else begin
          data_q[0]  <= vec_i[LO +: DATA_WIDTH];
          valid_q[0] <= valid_i;
          for (int s = 1; s < i; s++) begin
            data_q[s]  <= data_q[s-1];
            valid_q[s] <= valid_q[s-1];
          end
        end
      end

      assign vec_o[LO +: DATA_WIDTH] = valid_q[i-1] ? data_q[i-1] : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_controller.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_controller
//  Purpose  : Sequencer for an ARRAY_SIZE x ARRAY_SIZE systolic array:
//             clear, fetch K operand vectors, skew them onto the array
//             edges, drain the wavefront, then stream out result rows.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_controller
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int DATA_WIDTH = 16,
  parameter int K_MAX      = 256,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [ADDR_WIDTH:0]               k_len,
  output logic                              busy,
  output logic                              done,
  output logic                              a_rd_en,
  output logic [ADDR_WIDTH-1:0]             a_rd_addr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]  a_rd_data,
  output logic                              b_rd_en,
  output logic [ADDR_WIDTH-1:0]             b_rd_addr,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]  b_rd_data,
  output logic                              array_clear,
  output logic                              accumulate_enable,
  output logic                              read_enable,
  output logic [31:0]                       row_index,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]  west_inputs,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]  north_inputs,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]  array_results,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]  res_data,
  output logic [$clog2(ARRAY_SIZE)-1:0]     res_row
);

  localparam int DRAIN_CYCLES = drain_cycles(ARRAY_SIZE);
  localparam int ROW_W        = row_w(ARRAY_SIZE);
  localparam int DRN_W        = $clog2(DRAIN_CYCLES) + 1;
  localparam int DRAIN_LAST_I = DRAIN_CYCLES - 1;
  localparam int ROW_LAST_I   = ARRAY_SIZE - 1;

  localparam logic [ADDR_WIDTH:0] K_MAX_V    = K_MAX[ADDR_WIDTH:0];
  localparam logic [DRN_W-1:0]    DRAIN_INIT = DRAIN_LAST_I[DRN_W-1:0];
  localparam logic [ROW_W:0]      ROW_LAST   = ROW_LAST_I[ROW_W:0];

  state_t                state_q;
  logic [ADDR_WIDTH:0]   k_len_q;
  logic [ADDR_WIDTH:0]   feed_cnt_q;
  logic [DRN_W-1:0]      drain_cnt_q;
  logic [ROW_W:0]        row_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic                  rd_valid_q;
  logic                  clear_q;
  logic                  acc_en_q;
  logic                  read_en_q;
  logic                  res_valid_q;
  logic                  done_q;
  logic                  busy_q;

  logic                  k_ok;
  logic [ADDR_WIDTH:0]   feed_cnt_d;

  assign k_ok       = (k_len != '0) && (k_len <= K_MAX_V);
  assign feed_cnt_d = feed_cnt_q + 1'b1;

  // Sequencer: state, counters and every control output registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_len_q     <= '0;
      feed_cnt_q  <= '0;
      drain_cnt_q <= '0;
      row_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      clear_q     <= 1'b0;
      acc_en_q    <= 1'b0;
      read_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && k_ok) begin
            state_q <= S_CLEAR;
            k_len_q <= k_len;
            busy_q  <= 1'b1;
            clear_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q    <= S_FEED;
          clear_q    <= 1'b0;
          rd_en_q    <= 1'b1;
          rd_addr_q  <= '0;
          feed_cnt_q <= '0;
          acc_en_q   <= 1'b1;
        end
        S_FEED: begin
          if (feed_cnt_d == k_len_q) begin
            state_q     <= S_DRAIN;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            feed_cnt_q  <= '0;
            drain_cnt_q <= DRAIN_INIT;
          end else begin
            feed_cnt_q <= feed_cnt_d;
            rd_addr_q  <= feed_cnt_d[ADDR_WIDTH-1:0];
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q     <= S_READ;
            acc_en_q    <= 1'b0;
            read_en_q   <= 1'b1;
            res_valid_q <= 1'b1;
            row_q       <= '0;
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        S_READ: begin
          if (res_ready) begin
            if (row_q == ROW_LAST) begin
              state_q     <= S_DONE;
              read_en_q   <= 1'b0;
              res_valid_q <= 1'b0;
              row_q       <= '0;
              done_q      <= 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read data returns one cycle after the strobe; track it for the skew lines
  always_ff @(posedge clk) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_en_q;
  end

  skew_buffer #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew_west (
    .clk     (clk),
    .rst     (rst),
    .vec_i   (a_rd_data),
    .valid_i (rd_valid_q),
    .vec_o   (west_inputs)
  );

  skew_buffer #(
    .ARRAY_SIZE (ARRAY_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skew_north (
    .clk     (clk),
    .rst     (rst),
    .vec_i   (b_rd_data),
    .valid_i (rd_valid_q),
    .vec_o   (north_inputs)
  );

  assign busy              = busy_q;
  assign done              = done_q;
  assign a_rd_en           = rd_en_q;
  assign a_rd_addr         = rd_addr_q;
  assign b_rd_en           = rd_en_q;
  assign b_rd_addr         = rd_addr_q;
  assign array_clear       = clear_q;
  assign accumulate_enable = acc_en_q;
  assign read_enable       = read_en_q;
  assign row_index         = 32'(row_q);
  assign res_valid         = res_valid_q;
  assign res_row           = row_q[ROW_W-1:0];
  assign res_data          = res_valid_q ? array_results : '0;

endmodule
`default_nettype wire

// File: tb/tb_systolic_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_controller
//  Purpose  : Directed bench for the systolic sequencer with a behavioural
//             4x4 output-stationary array and registered operand buffers.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_controller;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int KM = 256;
  localparam int AW = 8;
  localparam int VW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   k_len;
  logic          busy, done;
  logic          a_rd_en, b_rd_en;
  logic [AW-1:0] a_rd_addr, b_rd_addr;
  logic [VW-1:0] a_rd_data, b_rd_data;
  logic          array_clear, accumulate_enable, read_enable;
  logic [31:0]   row_index;
  logic [VW-1:0] west_inputs, north_inputs, array_results, res_data;
  logic          res_valid, res_ready;
  logic [1:0]    res_row;

  int n_checks = 0;
  int n_pass   = 0;

  logic [VW-1:0] a_mem [KM];
  logic [VW-1:0] b_mem [KM];
  logic [VW-1:0] exp_rows [N];

  logic [W-1:0] pa [N][N];
  logic [W-1:0] pb [N][N];
  logic [W-1:0] acc [N][N];
  logic [W-1:0] ain_w [N][N];
  logic [W-1:0] bin_w [N][N];

  always #5 clk = ~clk;

  systolic_controller #(
    .ARRAY_SIZE (N),
    .DATA_WIDTH (W),
    .K_MAX      (KM),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .k_len             (k_len),
    .busy              (busy),
    .done              (done),
    .a_rd_en           (a_rd_en),
    .a_rd_addr         (a_rd_addr),
    .a_rd_data         (a_rd_data),
    .b_rd_en           (b_rd_en),
    .b_rd_addr         (b_rd_addr),
    .b_rd_data         (b_rd_data),
    .array_clear       (array_clear),
    .accumulate_enable (accumulate_enable),
    .read_enable       (read_enable),
    .row_index         (row_index),
    .west_inputs       (west_inputs),
    .north_inputs      (north_inputs),
    .array_results     (array_results),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_data          (res_data),
    .res_row           (res_row)
  );

  function automatic logic [W-1:0] lane(input logic [VW-1:0] v, input int i);
    return v[(N-1-i)*W +: W];
  endfunction

  // Operand buffers: one-cycle registered read
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  // Array PE inputs: edge lanes or the neighbour's forwarded operand
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ain_w[i][0] = lane(west_inputs, i);
      bin_w[0][i] = lane(north_inputs, i);
      for (int j = 1; j < N; j++) begin
        ain_w[i][j] = pa[i][j-1];
        bin_w[j][i] = pb[j-1][i];
      end
    end
  end

  // Array PEs: forward operands east/south, accumulate when enabled
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || array_clear) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j] <= ain_w[i][j];
          pb[i][j] <= bin_w[i][j];
          if (accumulate_enable) acc[i][j] <= acc[i][j] + ain_w[i][j] * bin_w[i][j];
        end
      end
    end
  end

  // Result row selected by row_index
  always_comb begin
    array_results = '0;
    if (row_index < 32'(N)) begin
      for (int j = 0; j < N; j++) array_results[(N-1-j)*W +: W] = acc[row_index[1:0]][j];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_flags"}, 64'({busy, done, a_rd_en, b_rd_en, array_clear,
                                accumulate_enable, read_enable, res_valid}), 64'(0));
    check({tag, "_addr"},  64'({a_rd_addr, b_rd_addr, res_row}), 64'(0));
    check({tag, "_rowidx"}, 64'(row_index), 64'(0));
    check({tag, "_west"},  64'(west_inputs), 64'(0));
    check({tag, "_north"}, 64'(north_inputs), 64'(0));
    check({tag, "_rdata"}, 64'(res_data), 64'(0));
  endtask

  task automatic run_job(input int k, input int stall_row, input int stall_len,
                         input bit skew_chk, input bit inject);
    int guard, addr_exp, first_rd, last_rd, first_rv, acc_cnt, w0, w2, n2, row_exp, stall_n;
    logic [AW-1:0] last_addr;
    start = 1'b1;
    k_len = (AW+1)'(k);
    @(negedge clk);
    start = 1'b0;
    check("clear_cycle", 64'({busy, array_clear, accumulate_enable, a_rd_en}), 64'(4'b1100));
    addr_exp = 0; first_rd = -1; last_rd = -1; first_rv = -1; acc_cnt = 0;
    w0 = -1; w2 = -1; n2 = -1; guard = 0; last_addr = '0;
    while (first_rv < 0 && guard < k + 4*N + 8) begin
      @(negedge clk);
      guard++;
      if (inject) begin
        if (guard == 2) begin start = 1'b1; k_len = 9'd2; end
        else start = 1'b0;
      end
      if (a_rd_en) begin
        check("rd_addr", 64'(a_rd_addr), 64'(addr_exp));
        check("b_rd", 64'({b_rd_en, b_rd_addr}), 64'({1'b1, AW'(addr_exp)}));
        if (first_rd < 0) first_rd = guard;
        last_rd   = guard;
        last_addr = a_rd_addr;
        addr_exp++;
      end
      if (accumulate_enable) acc_cnt++;
      if (w0 < 0 && lane(west_inputs, 0) != '0) w0 = guard;
      if (w2 < 0 && lane(west_inputs, 2) != '0) w2 = guard;
      if (n2 < 0 && lane(north_inputs, 2) != '0) n2 = guard;
      if (res_valid) first_rv = guard;
    end
    start = 1'b0;
    if (first_rv < 0) check("feed_drain_timeout", 64'(0), 64'(1));
    check("feed_len",    64'(addr_exp), 64'(k));
    check("feed_contig", 64'(last_rd - first_rd + 1), 64'(k));
    check("last_addr",   64'(last_addr), 64'(k - 1));
    check("drain_len",   64'(first_rv - last_rd), 64'(2*N + 1));
    check("acc_window",  64'(acc_cnt), 64'(k + 2*N));
    if (skew_chk) begin
      check("west0_lat",   64'(w0), 64'(first_rd + 1));
      check("west2_skew",  64'(w2 - w0), 64'(2));
      check("north2_skew", 64'(n2 - w0), 64'(2));
    end
    row_exp = 0; stall_n = 0; guard = 0;
    while (row_exp < N && guard < N + stall_len + 8) begin
      guard++;
      check("read_flags", 64'({res_valid, read_enable, accumulate_enable, busy, done}), 64'(5'b11010));
      check("res_row",    64'(res_row), 64'(row_exp));
      check("row_index",  64'(row_index), 64'(row_exp));
      check("res_data",   64'(res_data), 64'(exp_rows[row_exp]));
      if (row_exp == stall_row && stall_n < stall_len) begin
        res_ready = 1'b0;
        stall_n++;
      end else begin
        res_ready = 1'b1;
        row_exp++;
      end
      @(negedge clk);
    end
    res_ready = 1'b1;
    if (row_exp < N) check("read_timeout", 64'(0), 64'(1));
    check("done_pulse", 64'({done, busy, read_enable, res_valid}), 64'(4'b1100));
    @(negedge clk);
    check("idle_after_done", 64'({done, busy}), 64'(0));
  endtask

  task automatic pulse_bad(input logic [AW:0] k, input string tag);
    start = 1'b1;
    k_len = k;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check(tag, 64'({busy, done, array_clear, a_rd_en}), 64'(0));
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; res_ready = 1'b1;
    for (int k = 0; k < KM; k++) begin a_mem[k] = '0; b_mem[k] = '0; end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    @(negedge clk);

    // Outer product, k = 1
    a_mem[0] = {16'd1, 16'd2, 16'd3, 16'd4};
    b_mem[0] = {16'd5, 16'd6, 16'd7, 16'd8};
    exp_rows[0] = {16'd5,  16'd6,  16'd7,  16'd8};
    exp_rows[1] = {16'd10, 16'd12, 16'd14, 16'd16};
    exp_rows[2] = {16'd15, 16'd18, 16'd21, 16'd24};
    exp_rows[3] = {16'd20, 16'd24, 16'd28, 16'd32};
    run_job(1, -1, 0, 1'b1, 1'b0);

    // Same job with a 5-cycle stall at row 1
    run_job(1, 1, 5, 1'b0, 1'b0);

    // Identity x identity, k = 4
    for (int k = 0; k < N; k++) begin
      a_mem[k]    = 64'h1 << ((N-1-k)*W);
      b_mem[k]    = 64'h1 << ((N-1-k)*W);
      exp_rows[k] = 64'h1 << ((N-1-k)*W);
    end
    run_job(4, -1, 0, 1'b0, 1'b0);

    // Start during FEED ignored, then bad lengths ignored in IDLE
    run_job(4, -1, 0, 1'b0, 1'b1);
    pulse_bad(9'd0,   "klen0_ignored");
    pulse_bad(9'd257, "klen_over_ignored");

    // Reset in DRAIN
    start = 1'b1; k_len = 9'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("in_drain", 64'({busy, accumulate_enable, a_rd_en, res_valid}), 64'(4'b1100));
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      a_mem[k] = 64'h0001_0001_0001_0001;
      b_mem[k] = 64'h0001_0001_0001_0001;
    end
    for (int r = 0; r < N; r++) exp_rows[r] = 64'h0002_0002_0002_0002;
    run_job(2, -1, 0, 1'b1, 1'b0);

    // Full length, all ones
    for (int k = 0; k < KM; k++) begin
      a_mem[k] = 64'h0001_0001_0001_0001;
      b_mem[k] = 64'h0001_0001_0001_0001;
    end
    for (int r = 0; r < N; r++) exp_rows[r] = 64'h0100_0100_0100_0100;
    run_job(256, -1, 0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
